// File: rtl/entradas_semaforo_pkg.sv
// semaforo_pkg: shared constants for the traffic-light input stage and FSM
package semaforo_pkg;
    localparam int DEBOUNCE_CYC_DEF = 4;
    localparam int TICK_DIV_DEF     = 10;
    localparam int MIN_GREEN_DEF    = 3;
    localparam int MAX_GREEN_DEF    = 8;
    localparam int AVENIDA          = 0;
    localparam int BOULEVARD        = 1;
endpackage

// File: rtl/entradas_semaforo_if.sv
// entradas_semaforo_if: raw sensor/button inputs, green feedback and conditioned FSM inputs
interface entradas_semaforo_if;
    logic       sensor_a_raw;
    logic       sensor_b_raw;
    logic       btn_e_raw;
    logic       btn_r_raw;
    logic [1:0] verde;
    logic       TA;
    logic       TB;
    logic       E;
    logic       R;
    modport master (
        output sensor_a_raw, sensor_b_raw, btn_e_raw, btn_r_raw, verde,
        input  TA, TB, E, R
    );
    modport slave (
        input  sensor_a_raw, sensor_b_raw, btn_e_raw, btn_r_raw, verde,
        output TA, TB, E, R
    );
endinterface

// File: rtl/entradas_semaforo_antirrebote.sv
// antirrebote: 2-FF synchronizer followed by a consecutive-cycle debouncer
module antirrebote
    import semaforo_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic stable
);
    localparam int CW = $clog2(DEBOUNCE_CYC + 1);
    logic [1:0]    sync;
    logic [CW-1:0] cnt;
    // stable flips only after DEBOUNCE_CYC consecutive cycles of disagreement
    always_ff @(posedge clk) begin
        if (reset) begin
            sync   <= '0;
            cnt    <= '0;
            stable <= 1'b0;
        end else begin
            sync <= {sync[0], raw};
            if (sync[1] == stable) cnt <= '0;
            else if (cnt == CW'(DEBOUNCE_CYC - 1)) begin
                stable <= ~stable;
                cnt    <= '0;
            end else cnt <= cnt + CW'(1);
        end
    end
endmodule

// File: rtl/entradas_semaforo.sv
// entradas_semaforo: conditions sensors/buttons and enforces green dwell limits for the FSM
module entradas_semaforo
    import semaforo_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
    parameter int TICK_DIV     = TICK_DIV_DEF,
    parameter int MIN_GREEN    = MIN_GREEN_DEF,
    parameter int MAX_GREEN    = MAX_GREEN_DEF
) (
    input logic                clk,
    input logic                reset,
    entradas_semaforo_if.slave bus
);
    localparam int PW = $clog2(TICK_DIV);
    localparam int DW = $clog2(MAX_GREEN + 1);
    logic          sa, sb, se, sr;
    logic [PW-1:0] pres;
    logic [DW-1:0] dwell_a, dwell_b;
    logic          tick, ta, tb, e, r_flag, r_prev;

    antirrebote #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_sa (.clk(clk), .reset(reset), .raw(bus.sensor_a_raw), .stable(sa));
    antirrebote #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_sb (.clk(clk), .reset(reset), .raw(bus.sensor_b_raw), .stable(sb));
    antirrebote #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_se (.clk(clk), .reset(reset), .raw(bus.btn_e_raw), .stable(se));
    antirrebote #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_sr (.clk(clk), .reset(reset), .raw(bus.btn_r_raw), .stable(sr));

    assign tick = pres == PW'(TICK_DIV - 1);

    // free-running prescaler producing one tick every TICK_DIV cycles
    always_ff @(posedge clk) begin
        if (reset) pres <= '0;
        else pres <= tick ? '0 : pres + PW'(1);
    end

    // per-street green dwell in ticks; leaving green clears even on a tick
    always_ff @(posedge clk) begin
        if (reset) begin
            dwell_a <= '0;
            dwell_b <= '0;
        end else begin
            dwell_a <= !bus.verde[AVENIDA] ? '0 :
                       (tick && dwell_a != DW'(MAX_GREEN)) ? dwell_a + DW'(1) : dwell_a;
            dwell_b <= !bus.verde[BOULEVARD] ? '0 :
                       (tick && dwell_b != DW'(MAX_GREEN)) ? dwell_b + DW'(1) : dwell_b;
        end
    end

    // hold requests: forced during minimum green, dropped at maximum if the other street waits
    always_ff @(posedge clk) begin
        if (reset) begin
            ta <= 1'b1;
            tb <= 1'b1;
            e  <= 1'b0;
        end else begin
            ta <= (dwell_a < DW'(MIN_GREEN)) | (sa & ~(sb & (dwell_a == DW'(MAX_GREEN))));
            tb <= (dwell_b < DW'(MIN_GREEN)) | (sb & ~(sa & (dwell_b == DW'(MAX_GREEN))));
            e  <= se;
        end
    end

    // maintenance mode toggles once per press of the debounced button
    always_ff @(posedge clk) begin
        if (reset) begin
            r_flag <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_prev <= sr;
            if (sr && !r_prev) r_flag <= ~r_flag;
        end
    end

    assign bus.TA = ta;
    assign bus.TB = tb;
    assign bus.E  = e;
    assign bus.R  = r_flag;
endmodule

// File: tb/tb_entradas_semaforo.sv
// tb_entradas_semaforo: directed checks of debounce, dwell limits, maintenance toggle and reset
module tb_entradas_semaforo;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    entradas_semaforo_if bus ();

    entradas_semaforo dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic quiet();
        bus.sensor_a_raw = 1'b0;
        bus.sensor_b_raw = 1'b0;
        bus.btn_e_raw    = 1'b0;
        bus.btn_r_raw    = 1'b0;
        bus.verde        = 2'b00;
    endtask

    task automatic restart();
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
    endtask

    initial begin
        bus.sensor_a_raw = 1'($urandom);
        bus.sensor_b_raw = 1'($urandom);
        bus.btn_e_raw    = 1'($urandom);
        bus.btn_r_raw    = 1'($urandom);
        bus.verde        = 2'($urandom);
        cyc(2);
        chk("rst_ta", int'(bus.TA), 1);
        chk("rst_tb", int'(bus.TB), 1);
        chk("rst_e", int'(bus.E), 0);
        chk("rst_r", int'(bus.R), 0);
        chk("rst_dwell_a", int'(dut.dwell_a), 0);
        chk("rst_dwell_b", int'(dut.dwell_b), 0);
        chk("rst_pres", int'(dut.pres), 0);
        quiet();

        reset = 1'b0;
        bus.btn_e_raw = 1'b1;
        cyc(3);
        bus.btn_e_raw = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            chk("e_glitch", int'(bus.E), 0);
        end
        bus.btn_e_raw = 1'b1;
        cyc(6);
        chk("e_before", int'(bus.E), 0);
        cyc(1);
        chk("e_rise", int'(bus.E), 1);
        cyc(5);
        bus.btn_e_raw = 1'b0;
        cyc(6);
        chk("e_hold", int'(bus.E), 1);
        cyc(1);
        chk("e_fall", int'(bus.E), 0);

        restart();
        bus.verde = 2'b01;
        cyc(29);
        chk("min_dwell29", int'(dut.dwell_a), 2);
        chk("min_ta29", int'(bus.TA), 1);
        cyc(1);
        chk("min_dwell30", int'(dut.dwell_a), 3);
        chk("min_ta30", int'(bus.TA), 1);
        cyc(1);
        chk("min_ta31", int'(bus.TA), 0);
        chk("min_tb31", int'(bus.TB), 1);
        cyc(8);
        bus.verde = 2'b00;
        cyc(1);
        chk("clear_wins", int'(dut.dwell_a), 0);

        restart();
        bus.verde        = 2'b01;
        bus.sensor_a_raw = 1'b1;
        bus.sensor_b_raw = 1'b1;
        cyc(80);
        chk("max_dwell80", int'(dut.dwell_a), 8);
        chk("max_ta80", int'(bus.TA), 1);
        cyc(1);
        chk("max_ta81", int'(bus.TA), 0);
        chk("max_tb81", int'(bus.TB), 1);
        bus.sensor_b_raw = 1'b0;
        cyc(6);
        chk("max_ta87", int'(bus.TA), 0);
        cyc(1);
        chk("max_ta88", int'(bus.TA), 1);
        cyc(30);
        chk("max_ta_keep", int'(bus.TA), 1);
        chk("max_sat", int'(dut.dwell_a), 8);
        quiet();

        restart();
        bus.btn_r_raw = 1'b1;
        cyc(6);
        chk("r_before", int'(bus.R), 0);
        cyc(1);
        chk("r_set", int'(bus.R), 1);
        cyc(13);
        chk("r_held", int'(bus.R), 1);
        bus.btn_r_raw = 1'b0;
        cyc(10);
        chk("r_released", int'(bus.R), 1);
        bus.btn_r_raw = 1'b1;
        cyc(6);
        chk("r_before2", int'(bus.R), 1);
        cyc(1);
        chk("r_clear", int'(bus.R), 0);
        bus.btn_r_raw = 1'b0;

        restart();
        bus.verde     = 2'b10;
        bus.btn_r_raw = 1'b1;
        cyc(10);
        bus.btn_r_raw = 1'b0;
        cyc(45);
        chk("mid_dwell_b", int'(dut.dwell_b), 5);
        chk("mid_tb", int'(bus.TB), 0);
        chk("mid_r", int'(bus.R), 1);
        restart();
        chk("mid_rst_dwell_b", int'(dut.dwell_b), 0);
        chk("mid_rst_tb", int'(bus.TB), 1);
        chk("mid_rst_r", int'(bus.R), 0);
        chk("mid_rst_pres", int'(dut.pres), 0);
        cyc(9);
        chk("restart_dwell9", int'(dut.dwell_b), 0);
        cyc(1);
        chk("restart_dwell10", int'(dut.dwell_b), 1);

        restart();
        bus.verde = 2'b11;
        cyc(10);
        chk("both_dwell_a", int'(dut.dwell_a), 1);
        chk("both_dwell_b", int'(dut.dwell_b), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/entradas_semaforo.md
Name: entradas_semaforo

Overview:
Input-conditioning stage that sits directly upstream of the traffic-light FSM and produces its TA, TB, E and R inputs. It synchronizes and debounces the raw vehicle sensors and the two push-buttons. It enforces minimum and maximum green dwell times using the FSM's light outputs, fed back as `verde`. It also turns the maintenance button into a latched mode level.

Parameters:
- DEBOUNCE_CYC, 4: consecutive clk cycles a synchronized input must differ from its stable value before the stable value flips; must be ≥1.
- TICK_DIV, 10: clk cycles per timing tick; must be ≥2.
- MIN_GREEN, 3: ticks a street keeps its T signal forced high after its green starts.
- MAX_GREEN, 8: ticks after which a green street yields if the other street has demand; must be > MIN_GREEN.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- sensor_a_raw  in  1  avenue vehicle sensor, asynchronous
- sensor_b_raw  in  1  boulevard vehicle sensor, asynchronous
- btn_e_raw  in  1  emergency button, asynchronous
- btn_r_raw  in  1  maintenance button, asynchronous
- verde  in  2  FSM green feedback: bit0 = avenue, bit1 = boulevard
- TA  out  1  avenue traffic/hold request to the FSM
- TB  out  1  boulevard traffic/hold request to the FSM
- E  out  1  debounced emergency level
- R  out  1  latched maintenance mode

Behaviour:
- Single clock domain. Reset is synchronous and active-high; all state changes only on the rising edge of clk.
- Reset values:
  - synchronizer flops, stable values, debounce counters, prescaler, dwell counters, R flag and previous-button register: all 0
  - outputs: TA=1, TB=1, E=0, R=0
- Synchronizer: each raw input passes through 2 flip-flops.
- Debounce, per input:
  - The counter increments while the synchronized value differs from the stable value and clears to 0 when they are equal.
  - When the counter is at DEBOUNCE_CYC-1 and the values still differ, the stable value flips and the counter clears.
  - A pulse shorter than DEBOUNCE_CYC cycles at the synchronizer output never changes the stable value.
- Latency: a raw level change sampled at edge k is visible on the output after edge k+DEBOUNCE_CYC+2.
- Prescaler: free-running counter 0..TICK_DIV-1; tick is a 1-cycle pulse when the count equals TICK_DIV-1, after which it wraps to 0.
- Dwell counters dwell_a and dwell_b:
  - dwell_a clears to 0 whenever verde[0]=0.
  - While verde[0]=1 it increments on each tick and saturates at MAX_GREEN.
  - dwell_b behaves the same way with verde[1].
  - Width is $clog2(MAX_GREEN+1).
- Registered outputs, updated every cycle:
  - TA <= (dwell_a < MIN_GREEN) | (sa & ~(sb & dwell_a == MAX_GREEN)), where sa and sb are the stable sensor values.
  - TB <= (dwell_b < MIN_GREEN) | (sb & ~(sa & dwell_b == MAX_GREEN)).
  - E <= stable emergency value.
- R flag:
  - Toggles on a rising edge of the stable maintenance-button value, detected with a previous-value register.
  - A held button toggles it exactly once.
  - R output equals the flag.
- Simultaneous events:
  - E and R are independent; both may be 1 at once. The FSM resolves priority.
  - verde=2'b11 is illegal; if it occurs, both dwell counters run and no error is flagged.
  - A tick and a verde falling edge in the same cycle clear the counter (clear wins).
- Reset mid-operation forces every register back to its reset value on the next edge, regardless of counter or debounce progress.

Decomposition:
- Package semaforo_pkg holds:
  - default constants DEBOUNCE_CYC_DEF, TICK_DIV_DEF, MIN_GREEN_DEF and MAX_GREEN_DEF
  - index constants AVENIDA=0 and BOULEVARD=1 for the verde/amarillo/rojo buses, shared with the FSM
- One sub-module, antirrebote (parameter DEBOUNCE_CYC; ports clk, reset, raw, stable), instantiated four times.
- The 2-FF synchronizer lives inside antirrebote.

Test Plan (all parameters at their defaults):
1. Assert reset for 2 cycles with random inputs → TA=1, TB=1, E=0, R=0; dwell counters and prescaler read 0.
2. btn_e_raw=1 for 3 cycles, then 0 → E stays 0. btn_e_raw=1 held 12 cycles from edge k → E=1 after edge k+6.
3. verde=01, sensor_a=0, sensor_b=0 → TA=1 until dwell_a reaches 3 (≈30 cycles after verde rises), then TA=0 on the next edge.
4. verde=01, sensor_a=1, sensor_b=1 → TA stays 1 until dwell_a=8, then TA=0. With sensor_b=0, TA remains 1 indefinitely.
5. Press btn_r for 20 cycles → R=1 once, with no re-toggle while held. Release, then press again → R=0.
6. verde=10 with dwell_b=5, pulse reset for 1 cycle → next edge shows dwell_b=0, TB=1 and R=0; counting restarts from tick 0.
